// File: rtl/control_sequencer.sv
// Control sequencer: multi-cycle fetch/execute state machine that decodes the
// registered T-state and the instruction register into datapath strobes.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic [31:0] Rin,
    output logic [31:0] Rout,
    output logic [15:0] ALUControl,
    output logic        IRin,
    output logic        MARin,
    output logic        RYin,
    output logic        MDRread,
    output logic        RZout,
    output logic        RBin,
    output logic        PCjump,
    output logic        done,
    output logic        halted,
    output logic [3:0]  phase
);

    localparam int unsigned STROBE_W  = 32;
    localparam int unsigned ALU_W     = 16;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned REG_IDX_W = 4;

    // Special-register strobe positions shared by Rin and Rout
    localparam int unsigned HI_BIT    = 16;
    localparam int unsigned LO_BIT    = 17;
    localparam int unsigned ZHIGH_BIT = 18;
    localparam int unsigned ZLOW_BIT  = 19;
    localparam int unsigned PC_BIT    = 20;
    localparam int unsigned MDR_BIT   = 21;

    localparam logic [OP_W-1:0] OP_ALU_MAX = 5'd11;
    localparam logic [OP_W-1:0] OP_MUL     = 5'd14;
    localparam logic [OP_W-1:0] OP_DIV     = 5'd15;
    localparam logic [OP_W-1:0] OP_HALT    = 5'd31;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t state;
    state_t next_state;

    logic [OP_W-1:0]      opcode;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic                 is_alu;
    logic                 is_muldiv;
    logic                 is_halt;
    logic                 unused_ir_low;

    // One-hot general-register strobe from a 4-bit register index
    function automatic logic [STROBE_W-1:0] reg_sel(input logic [REG_IDX_W-1:0] idx);
        reg_sel = STROBE_W'(1) << idx;
    endfunction

    // Instruction field extraction and opcode classification
    assign opcode        = IR[31:27];
    assign ra            = IR[26:23];
    assign rb            = IR[22:19];
    assign rc            = IR[18:15];
    assign is_alu        = (opcode <= OP_ALU_MAX);
    assign is_muldiv     = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_halt       = (opcode == OP_HALT);
    assign unused_ir_low = ^IR[14:0];

    // State register with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode for the current T-state
    always_comb begin
        next_state = state;
        Rin        = '0;
        Rout       = '0;
        ALUControl = '0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        RYin       = 1'b0;
        MDRread    = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) next_state = S_T0;
            end
            S_T0: begin
                Rout[PC_BIT]  = 1'b1;
                MARin         = 1'b1;
                Rin[ZLOW_BIT] = 1'b1;
                next_state    = S_T1;
            end
            S_T1: begin
                Rout[ZLOW_BIT] = 1'b1;
                Rin[PC_BIT]    = 1'b1;
                Rin[MDR_BIT]   = 1'b1;
                MDRread        = 1'b1;
                next_state     = S_T2;
            end
            S_T2: begin
                Rout[MDR_BIT] = 1'b1;
                IRin          = 1'b1;
                if (is_alu || is_muldiv) begin
                    next_state = S_T3;
                end else if (is_halt) begin
                    done       = 1'b1;
                    next_state = S_HALT;
                end else begin
                    done       = 1'b1;
                    next_state = run ? S_T0 : S_IDLE;
                end
            end
            S_T3: begin
                Rout       = is_muldiv ? reg_sel(ra) : reg_sel(rb);
                RYin       = 1'b1;
                next_state = S_T4;
            end
            S_T4: begin
                Rin[ZLOW_BIT] = 1'b1;
                ALUControl    = ALU_W'(opcode);
                if (is_muldiv) begin
                    Rout           = reg_sel(rb);
                    Rin[ZHIGH_BIT] = 1'b1;
                end else begin
                    Rout = reg_sel(rc);
                end
                next_state = S_T5;
            end
            S_T5: begin
                Rout[ZLOW_BIT] = 1'b1;
                if (is_muldiv) begin
                    Rin[LO_BIT] = 1'b1;
                    next_state  = S_T6;
                end else begin
                    Rin        = reg_sel(ra);
                    done       = 1'b1;
                    next_state = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Rout[ZHIGH_BIT] = 1'b1;
                Rin[HI_BIT]     = 1'b1;
                done            = 1'b1;
                next_state      = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Status outputs and reserved strobes
    assign halted = (state == S_HALT);
    assign phase  = state;
    assign RZout  = 1'b0;
    assign RBin   = 1'b0;
    assign PCjump = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an
// instruction-sequence reference model.
module tb_control_sequencer;

    typedef struct packed {
        logic [3:0]  phase;
        logic [31:0] rin;
        logic [31:0] rout;
        logic [15:0] alu;
        logic [8:0]  ctl;   // {IRin,MARin,RYin,MDRread,done,halted,RZout,RBin,PCjump}
    } exp_t;

    localparam int POS_IDLE = -1;
    localparam int POS_HALT = -2;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        run   = 1'b0;
    logic [31:0] ir    = '0;
    logic [31:0] rin, rout;
    logic [15:0] alu_control;
    logic        ir_in, mar_in, ry_in, mdr_read, rz_out, rb_in, pc_jump;
    logic        done, halted;
    logic [3:0]  phase;

    int          errors = 0;
    int          checks = 0;
    int          m_pos  = POS_IDLE;
    logic [31:0] instr  = '0;
    logic [31:0] ir_hold = '0;

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .IR         (ir),
        .Rin        (rin),
        .Rout       (rout),
        .ALUControl (alu_control),
        .IRin       (ir_in),
        .MARin      (mar_in),
        .RYin       (ry_in),
        .MDRread    (mdr_read),
        .RZout      (rz_out),
        .RBin       (rb_in),
        .PCjump     (pc_jump),
        .done       (done),
        .halted     (halted),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle count of an instruction, T0 included
    function automatic int seq_len(input logic [31:0] w);
        logic [4:0] op;
        op = w[31:27];
        if (op <= 5'd11) return 6;
        if (op == 5'd14 || op == 5'd15) return 7;
        return 3;
    endfunction

    // Expected outputs at a given position in the instruction sequence
    function automatic exp_t exp_at(input int pos, input logic [31:0] w);
        exp_t e;
        logic [4:0] op;
        int len;
        op  = w[31:27];
        len = seq_len(w);
        e   = '0;
        if (pos == POS_HALT) begin
            e.phase  = 4'd8;
            e.ctl[3] = 1'b1;
        end else if (pos >= 0) begin
            e.phase = 4'(pos + 1);
            if (pos == len - 1) e.ctl[4] = 1'b1;
            case (pos)
                0: begin e.rout = 32'h0010_0000; e.rin = 32'h0008_0000; e.ctl[7] = 1'b1; end
                1: begin e.rout = 32'h0008_0000; e.rin = 32'h0030_0000; e.ctl[5] = 1'b1; end
                2: begin e.rout = 32'h0020_0000; e.ctl[8] = 1'b1; end
                3: begin
                    e.rout   = (len == 7) ? (32'd1 << w[26:23]) : (32'd1 << w[22:19]);
                    e.ctl[6] = 1'b1;
                end
                4: begin
                    e.alu = 16'(op);
                    if (len == 7) begin e.rout = 32'd1 << w[22:19]; e.rin = 32'h000C_0000; end
                    else          begin e.rout = 32'd1 << w[18:15]; e.rin = 32'h0008_0000; end
                end
                5: begin
                    e.rout = 32'h0008_0000;
                    e.rin  = (len == 7) ? 32'h0002_0000 : (32'd1 << w[26:23]);
                end
                6: begin e.rout = 32'h0004_0000; e.rin = 32'h0001_0000; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Drive one cycle, advance the model at the edge, compare just after it
    task automatic step(input logic clr, input logic rn);
        exp_t e;
        clear = clr;
        run   = rn;
        if (m_pos == 1) ir_hold = instr;
        ir = (m_pos >= 1) ? ir_hold : $urandom();
        @(posedge clock);
        if (clr)                          m_pos = POS_IDLE;
        else if (m_pos == POS_IDLE)       m_pos = rn ? 0 : POS_IDLE;
        else if (m_pos == POS_HALT)       m_pos = POS_HALT;
        else if (m_pos == seq_len(ir) - 1)
            m_pos = (ir[31:27] == 5'd31) ? POS_HALT : (rn ? 0 : POS_IDLE);
        else                              m_pos = m_pos + 1;
        #1;
        e = exp_at(m_pos, ir);
        check("phase", 32'(phase), 32'(e.phase));
        check("rin", rin, e.rin);
        check("rout", rout, e.rout);
        check("alu", 32'(alu_control), 32'(e.alu));
        check("ctl", 32'({ir_in, mar_in, ry_in, mdr_read, done, halted, rz_out, rb_in, pc_jump}),
              32'(e.ctl));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        r[31:27] = 5'($urandom_range(0, 31));
        return r;
    endfunction

    initial begin
        // Clear held two cycles with run high, then first fetch
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("clr_rout", rout, 32'h0);
        instr = 32'h7988_0000;
        step(1'b0, 1'b1);
        check("t0_phase", 32'(phase), 32'd1);
        check("t0_rout", rout, 32'h0010_0000);
        check("t0_rin", rin, 32'h0008_0000);

        // div R3,R1
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("div_t3_rout", rout, 32'h8);
        step(1'b0, 1'b1);
        check("div_t4_rin", rin, 32'h000C_0000);
        check("div_t4_alu", 32'(alu_control), 32'd15);
        step(1'b0, 1'b1);
        check("div_t5_rin", rin, 32'h0002_0000);
        instr = 32'h1A92_0000;
        step(1'b0, 1'b1);
        check("div_t6_done", 32'(done), 32'd1);

        // add R5,R2,R4 then back-to-back T0
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("add_t5_rin", rin, 32'h20);
        check("add_t5_done", 32'(done), 32'd1);
        instr = 32'h7988_0000;
        step(1'b0, 1'b1);
        check("add_next_t0", 32'(phase), 32'd1);

        // clear during T4 of a div
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("abort_in_t4", 32'(phase), 32'd5);
        step(1'b1, 1'b0);
        check("abort_phase", 32'(phase), 32'd0);
        check("abort_rin", rin, 32'h0);
        step(1'b0, 1'b0);

        // halt
        instr = 32'hF800_0000;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("halt_t2_done", 32'(done), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)));
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_phase", 32'(phase), 32'd8);
        step(1'b1, 1'b0);
        check("halt_cleared", 32'(phase), 32'd0);

        // undefined opcode with run dropped in T1
        instr = 32'h8000_0000;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("nop_t2_done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        check("nop_idle", 32'(phase), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_pos < 1) instr = rand_instr();
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
